// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the IF-stage program-counter sequencer.
// Optional alignment checking is enabled with the PC_ALIGN_CHECK_EN macro.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } seq_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_EXC    = 3'd2,
    SEL_JR     = 3'd3,
    SEL_JUMP   = 3'd4,
    SEL_BRANCH = 3'd5
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  function automatic logic is_redirect(input pc_sel_e s);
    return (s == SEL_EXC) || (s == SEL_JR) || (s == SEL_JUMP) || (s == SEL_BRANCH);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the pipeline control and the PC sequencer.
// misalign_o exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_sequencer_if #(parameter int XLEN = 32);
  logic            stall_i;
  logic            exc_i;
  logic            jr_i;
  logic [XLEN-1:0] jr_target_i;
  logic            jump_i;
  logic [25:0]     jump_index_i;
  logic            branch_i;
  logic [XLEN-1:0] branch_base_i;
  logic [XLEN-1:0] branch_off_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_inc_o;
  logic            fetch_valid_o;
  logic            flush_o;
`ifdef PC_ALIGN_CHECK_EN
  logic            misalign_o;
`endif

  modport master (
    output stall_i, exc_i, jr_i, jr_target_i, jump_i, jump_index_i,
           branch_i, branch_base_i, branch_off_i,
    input  pc_o, pc_inc_o, fetch_valid_o, flush_o
`ifdef PC_ALIGN_CHECK_EN
    , misalign_o
`endif
  );

  modport slave (
    input  stall_i, exc_i, jr_i, jr_target_i, jump_i, jump_index_i,
           branch_i, branch_base_i, branch_off_i,
    output pc_o, pc_inc_o, fetch_valid_o, flush_o
`ifdef PC_ALIGN_CHECK_EN
    , misalign_o
`endif
  );
endinterface

// File: rtl/cla_adder_n.sv
// Parametrised-width carry-lookahead adder built as a parallel-prefix
// (Kogge-Stone) carry tree; cin is folded in after the prefix.
module cla_adder_n #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int LVL = $clog2(W);

  logic [W-1:0] hp, g, p, gn, pn;
  logic [W:0]   c;

  always_comb begin
    hp = a ^ b;
    g  = a & b;
    p  = hp;
    gn = g;
    pn = p;
    for (int l = 0; l < LVL; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
          pn[i] = p[i] & p[i - (1 << l)];
        end
      end
      g = gn;
      p = pn;
    end
    // g/p now hold group generate/propagate over bits [i:0]
    c[0] = cin;
    for (int i = 0; i < W; i++) c[i+1] = g[i] | (p[i] & cin);
    sum  = hp ^ c[W-1:0];
    cout = c[W];
  end
endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC sequencer: PC register, fixed-priority next-PC select, boot
// cycle, flush pulse after redirects. Define PC_ALIGN_CHECK_EN for misalign_o.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          INC          = 4,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  localparam logic [1:0]      S_BOOT  = 2'(ST_BOOT);
  localparam logic [1:0]      S_RUN   = 2'(ST_RUN);
  localparam logic [1:0]      S_REDIR = 2'(ST_REDIR);
  localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0] EXC_PC  = XLEN'(EXC_VECTOR);
  localparam logic [XLEN-1:0] INC_W   = XLEN'(INC);

  logic [1:0]      state_q, state_nx;
  logic [XLEN-1:0] pc_q, pc_nx, pc_inc, br_off_inc, br_tgt;
  logic            flush_q, fv_q, redirect;
  logic            inc_cout_unused, br_cout_unused;
  pc_sel_e         sel;

  cla_adder_n #(.W(XLEN)) u_inc (
    .a(pc_q), .b(INC_W), .cin(1'b0), .sum(pc_inc), .cout(inc_cout_unused)
  );

  // Word offset scaled and pre-biased by INC so the target is one add.
  assign br_off_inc = (bus.branch_off_i << 2) + INC_W;

  cla_adder_n #(.W(XLEN)) u_br (
    .a(bus.branch_base_i), .b(br_off_inc), .cin(1'b0), .sum(br_tgt), .cout(br_cout_unused)
  );

  always_comb begin
    if (state_q == S_BOOT)    sel = SEL_HOLD;
    else if (bus.exc_i)       sel = SEL_EXC;
    else if (bus.jr_i)        sel = SEL_JR;
    else if (bus.jump_i)      sel = SEL_JUMP;
    else if (bus.branch_i)    sel = SEL_BRANCH;
    else if (bus.stall_i)     sel = SEL_HOLD;
    else                      sel = SEL_SEQ;
  end

  assign redirect = is_redirect(sel);

`ifdef PC_ALIGN_CHECK_EN
  logic mis_nx, misalign_q;
`endif

  always_comb begin
    pc_nx = pc_q;
    case (sel)
      SEL_SEQ:    pc_nx = pc_inc;
      SEL_EXC:    pc_nx = EXC_PC;
      SEL_JR:     pc_nx = bus.jr_target_i;
      SEL_JUMP:   pc_nx = {pc_inc[XLEN-1:28], bus.jump_index_i, 2'b00};
      SEL_BRANCH: pc_nx = br_tgt;
      default:    pc_nx = pc_q;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    mis_nx = 1'b0;
    if ((sel == SEL_JR || sel == SEL_BRANCH) && pc_nx[1:0] != 2'b00) begin
      mis_nx = 1'b1;
      pc_nx  = EXC_PC;
    end
`endif
  end

  assign state_nx = redirect ? S_REDIR : S_RUN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RST_PC;
      flush_q <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_nx;
      pc_q    <= pc_nx;
      flush_q <= redirect;
      fv_q    <= (state_nx != S_BOOT);
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= mis_nx;
  end
  assign bus.misalign_o = misalign_q;
`endif

  assign bus.pc_o          = pc_q;
  assign bus.pc_inc_o      = pc_inc;
  assign bus.fetch_valid_o = fv_q;
  assign bus.flush_o       = flush_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural
// next-PC model (default parameters).
module tb_pc_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN)) bus();
  pc_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0, passed = 0, fails = 0;

  logic [31:0] m_pc;
  logic        m_boot, m_flush, m_fv, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.stall_i = 0; bus.exc_i = 0; bus.jr_i = 0; bus.jump_i = 0; bus.branch_i = 0;
    bus.jr_target_i = '0; bus.jump_index_i = '0; bus.branch_base_i = '0; bus.branch_off_i = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1; m_flush = 0; m_fv = 0; m_mis = 0;
  endtask

  // Spec-level next state from the currently driven requests.
  task automatic model_edge();
    logic [31:0] inc, nx;
    logic red, mis;
    inc = m_pc + 32'd4;
    if (m_boot) begin
      m_boot = 0; m_fv = 1; m_flush = 0; m_mis = 0;
      return;
    end
    red = 1; mis = 0;
    if (bus.exc_i)         nx = 32'h8000_0180;
    else if (bus.jr_i)     nx = bus.jr_target_i;
    else if (bus.jump_i)   nx = {inc[31:28], bus.jump_index_i, 2'b00};
    else if (bus.branch_i) nx = bus.branch_base_i + 32'd4 + (bus.branch_off_i << 2);
    else begin
      red = 0;
      nx = bus.stall_i ? m_pc : inc;
    end
`ifdef PC_ALIGN_CHECK_EN
    if (!bus.exc_i && (bus.jr_i || (!bus.jump_i && bus.branch_i)) && nx[1:0] != 2'b00) begin
      nx = 32'h8000_0180; mis = 1;
    end
`endif
    m_pc = nx; m_flush = red; m_fv = 1; m_mis = mis;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     bus.pc_o, m_pc);
    chk({tag, ".pc_inc"}, bus.pc_inc_o, m_pc + 32'd4);
    chk({tag, ".fv"},     32'(bus.fetch_valid_o), 32'(m_fv));
    chk({tag, ".flush"},  32'(bus.flush_o), 32'(m_flush));
`ifdef PC_ALIGN_CHECK_EN
    chk({tag, ".mis"},    32'(bus.misalign_o), 32'(m_mis));
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset mid-cycle, check asynchronous effect, release on a negedge.
  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst_n = 1;
    #1 check_all({tag, "_rel"});
  endtask

  initial begin
    logic [31:0] r;
    clr();
    model_reset();
    #2 rst_n = 0;
    #1 check_all("reset");
    chk("reset_fv", 32'(bus.fetch_valid_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1;
    #1 check_all("boot");
    step("boot_edge");
    chk("boot_pc", bus.pc_o, 32'h0);
    chk("boot_fv", 32'(bus.fetch_valid_o), 32'h1);
    step("seq1"); chk("seq_4", bus.pc_o, 32'h4);
    step("seq2"); chk("seq_8", bus.pc_o, 32'h8);
    step("seq3"); chk("seq_12", bus.pc_o, 32'hC);

    // stall at 0x100
    bus.jr_i = 1; bus.jr_target_i = 32'h100;
    step("jr100"); clr();
    chk("jr100_flush", 32'(bus.flush_o), 32'h1);
    bus.stall_i = 1;
    repeat (3) begin
      step("stall");
      chk("stall_hold", bus.pc_o, 32'h100);
      chk("stall_noflush", 32'(bus.flush_o), 32'h0);
    end
    clr();
    step("resume"); chk("resume_104", bus.pc_o, 32'h104);

    // branch overrides stall
    bus.branch_i = 1; bus.branch_base_i = 32'h200; bus.branch_off_i = 32'hFFFF_FFFE; bus.stall_i = 1;
    step("branch"); clr();
    chk("branch_pc", bus.pc_o, 32'h1FC);
    chk("branch_flush", 32'(bus.flush_o), 32'h1);
    step("branch_after");
    chk("branch_flush_end", 32'(bus.flush_o), 32'h0);

    // priority then jump region
    bus.exc_i = 1; bus.jr_i = 1; bus.jr_target_i = 32'h400; bus.jump_i = 1; bus.jump_index_i = 26'h3FF_FFFF;
    step("prio"); clr();
    chk("prio_exc", bus.pc_o, 32'h8000_0180);
    bus.jr_i = 1; bus.jr_target_i = 32'h1000_0000;
    step("jr_region"); clr();
    bus.jump_i = 1; bus.jump_index_i = 26'h000_0010;
    step("jump"); clr();
    chk("jump_pc", bus.pc_o, 32'h1000_0040);

    // wrap
    bus.jr_i = 1; bus.jr_target_i = 32'hFFFF_FFFC;
    step("wrap_set"); clr();
    chk("wrap_inc", bus.pc_inc_o, 32'h0);
    step("wrap"); chk("wrap_pc", bus.pc_o, 32'h0);

    // reset during REDIR
    bus.jr_i = 1; bus.jr_target_i = 32'h300;
    step("redir"); clr();
    chk("redir_flush", 32'(bus.flush_o), 32'h1);
    async_reset("rst_redir");
    chk("rst_redir_flush", 32'(bus.flush_o), 32'h0);
    chk("rst_redir_pc", bus.pc_o, 32'h0);
    step("rst_boot");

`ifdef PC_ALIGN_CHECK_EN
    bus.jr_i = 1; bus.jr_target_i = 32'h402;
    step("misalign"); clr();
    chk("misalign_pc", bus.pc_o, 32'h8000_0180);
    chk("misalign_hi", 32'(bus.misalign_o), 32'h1);
    step("misalign_end");
    chk("misalign_lo", 32'(bus.misalign_o), 32'h0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      bus.exc_i    = ($urandom_range(0, 11) == 0);
      bus.jr_i     = ($urandom_range(0, 7) == 0);
      bus.jump_i   = ($urandom_range(0, 7) == 0);
      bus.branch_i = ($urandom_range(0, 5) == 0);
      bus.stall_i  = ($urandom_range(0, 3) == 0);
      r = $urandom;
      bus.jr_target_i = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom;
      bus.jump_index_i = r[25:0];
      r = $urandom;
      bus.branch_base_i = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
      bus.branch_off_i = $urandom;
      step("rand");
      if ($urandom_range(0, 49) == 0) begin
        clr();
        async_reset("rand_rst");
      end
    end
    clr();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the pipelined core's IF stage; the next generation of the fixed PC+4 adder.
Holds the PC register and computes sequential, branch, jump, register-jump and exception next-PC values with a fixed priority.
Supports pipeline stall, a post-redirect flush pulse, a boot cycle after reset and a fetch-valid qualifier for instruction memory.

Parameters:
XLEN, 32, PC width in bits; must be >= 32.
INC, 4, sequential increment in bytes; a power of two, at most 16.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h8000_0180, exception handler entry; zero-extended to XLEN.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard unit stall; PC holds
exc_i  in  1  exception redirect request
jr_i  in  1  register jump request
jr_target_i  in  XLEN  register jump target
jump_i  in  1  J/JAL request
jump_index_i  in  26  instruction index field
branch_i  in  1  taken branch, resolved in ID
branch_base_i  in  XLEN  PC of the branch instruction
branch_off_i  in  XLEN  sign-extended immediate, in words
pc_o  out  XLEN  current fetch PC
pc_inc_o  out  XLEN  pc_o + INC, combinational
fetch_valid_o  out  1  pc_o is a valid fetch this cycle
flush_o  out  1  one-cycle pulse to squash the IF/ID instruction after a redirect

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - pc_o = RESET_VECTOR
  - state = BOOT
  - fetch_valid_o = 0
  - flush_o = 0
- States are BOOT, RUN and REDIR.
  - BOOT lasts exactly one cycle after rst_n deasserts: PC holds, then the block moves to RUN. Requests during BOOT are ignored.
  - RUN: fetch_valid_o = 1.
  - REDIR is entered on the edge that loads a redirect target. It lasts one cycle: flush_o = 1, fetch_valid_o = 1 (the target is being fetched). It then returns to RUN, or to REDIR again if another redirect arrives.
- Next-PC priority, evaluated in RUN and REDIR:
  1. exc_i: EXC_VECTOR
  2. jr_i: jr_target_i
  3. jump_i: {pc_inc_o[XLEN-1:28], jump_index_i, 2'b00}
  4. branch_i: branch_base_i + INC + (branch_off_i << 2)
  5. stall_i: hold pc_o
  6. otherwise: pc_inc_o
- Any redirect (items 1-4) overrides stall_i in the same cycle.
- flush_o asserts only in the cycle after a redirect edge, never on a stall.
- Arithmetic is modulo 2^XLEN; pc_o = all-ones-minus-(INC-1) wraps to 0 with no flag.
- The branch offset shift discards the upper bits; overflow is ignored.
- Simultaneous requests: only the highest priority acts; lower ones are dropped and not queued.
- Reset mid-REDIR: flush_o drops immediately (asynchronously) and the block re-enters BOOT.
- All outputs are registered except pc_inc_o.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - If a selected jr or branch target has target[1:0] != 0, PC loads EXC_VECTOR instead.
  - misalign_o pulses high for one cycle aligned with flush_o.
- Undefined:
  - The port is absent.
  - Targets load unmodified; the low bits pass through.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum (BOOT, RUN, REDIR)
  - default vector constants
  - redirect-select encoding
- Sub-module cla_adder_n: parametrised-width carry-lookahead adder (a, b, cin -> sum, cout).
  - Instantiated twice: sequential increment and branch target.
  - Branch instance b input = (branch_off_i << 2) + INC, pre-formed as a constant add.

Test Plan:
- Reset then release with no requests -> pc_o = 0 for 2 cycles (BOOT), fetch_valid_o 0 then 1, pc_o = 4, 8, 12 on the following edges.
- At pc_o = 0x100, assert stall_i for 3 cycles -> pc_o holds 0x100, flush_o stays 0, then resumes at 0x104.
- branch_i with base 0x200 and offset 0xFFFF_FFFE, stall_i high in the same cycle -> pc_o = 0x1FC next edge, flush_o = 1 for exactly one cycle.
- Same cycle exc_i, jr_i (0x400) and jump_i -> pc_o = 0x8000_0180; then jump_i with index 0x0000010 at pc 0x1000_0000 -> pc_o = 0x1000_0040.
- pc_o = 0xFFFF_FFFC, no requests -> pc_o = 0x0000_0000.
- rst_n low during REDIR -> flush_o falls without a clock edge, pc_o = RESET_VECTOR. With PC_ALIGN_CHECK_EN, jr target 0x402 -> pc_o = 0x8000_0180 and misalign_o = 1 for one cycle.
